// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline hazard/sequencing controller.
//   irq_state_e : interrupt-entry FSM states
//   PC_SEQ/PC_BR/PC_IRQ : pc_sel encodings driven to the PC mux
//   NOP_INSTR   : instruction word the IF_ID register loads when if_id_nop is set
//   RA_REG      : register that receives the interrupt return address
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STORE = 2'd1,
        ST_ACK   = 2'd2
    } irq_state_e;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_IRQ = 2'b10;

    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam logic [3:0]  RA_REG    = 4'hf;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator.
// Flags a hazard when the EX instruction is a register-writing load whose
// destination (never r0, which is hardwired) is a source actually read by
// the instruction in ID.
//   id_p0_addr/id_p1_addr, id_use_p0/id_use_p1 : ID sources and their valid bits
//   ex_dst_addr, ex_we, ex_mem_re              : EX destination, write enable, load
//   load_use                                   : hazard present this cycle
module hazard_detect #(
    parameter int REG_AW = 4
) (
    input  logic [REG_AW-1:0] id_p0_addr,
    input  logic [REG_AW-1:0] id_p1_addr,
    input  logic              id_use_p0,
    input  logic              id_use_p1,
    input  logic [REG_AW-1:0] ex_dst_addr,
    input  logic              ex_we,
    input  logic              ex_mem_re,
    output logic              load_use
);
    import pipe_ctrl_pkg::*;

    logic p0_hit;
    logic p1_hit;
    logic ex_is_load;

    always_comb begin
        ex_is_load = ex_mem_re && ex_we && (ex_dst_addr != '0);
        p0_hit     = id_use_p0 && (id_p0_addr == ex_dst_addr);
        p1_hit     = id_use_p1 && (id_p1_addr == ex_dst_addr);
        load_use   = ex_is_load && (p0_hit || p1_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing controller for the five-stage pipeline.
// Produces stall/flush/bubble controls for IF_ID, ID_EX, EX_MEM and the PC mux,
// and sequences interrupt entry (return address captured into r15 via ID_EX).
//
// Optional feature: define PIPE_CTRL_PERF_EN to build a saturating counter of
// cycles with pc_stall set; otherwise stall_cnt is tied to zero.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   id_p0_addr/id_p1_addr, id_use_*  ID source registers
//   ex_dst_addr, ex_we, ex_mem_re    EX destination info
//   mem_access, mem_rdy              MEM stage handshake
//   ex_send, spart_full              SPART send backpressure
//   mispredict                       EX branch mispredict
//   irq, rti                         interrupt request / return
//   pc_stall, pc_sel                 PC control
//   if_id_stall, if_id_nop           IF_ID control
//   id_ex_stall, id_ex_flush         ID_EX control
//   ex_mem_stall                     EX_MEM control
//   store_current                    ID_EX writes return address
//   irq_ack, in_isr                  interrupt status
//   stall_cnt                        stall-cycle counter
//
// Interrupt FSM:
//   state    | meaning
//   ST_RUN   | normal execution, waiting for a hazard-free cycle to take irq
//   ST_STORE | redirect to vector, capture return address (holds on mem/send wait)
//   ST_ACK   | acknowledge, mask further interrupts
module pipe_ctrl #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_p0_addr,
    input  logic [REG_AW-1:0] id_p1_addr,
    input  logic              id_use_p0,
    input  logic              id_use_p1,
    input  logic [REG_AW-1:0] ex_dst_addr,
    input  logic              ex_we,
    input  logic              ex_mem_re,
    input  logic              mem_access,
    input  logic              mem_rdy,
    input  logic              ex_send,
    input  logic              spart_full,
    input  logic              mispredict,
    input  logic              irq,
    input  logic              rti,
    output logic              pc_stall,
    output logic [1:0]        pc_sel,
    output logic              if_id_stall,
    output logic              if_id_nop,
    output logic              id_ex_stall,
    output logic              id_ex_flush,
    output logic              ex_mem_stall,
    output logic              store_current,
    output logic              irq_ack,
    output logic              in_isr,
    output logic [CNT_W-1:0]  stall_cnt
);
    import pipe_ctrl_pkg::*;

    irq_state_e state_q, state_d;
    logic       irq_pend_q, irq_pend_d;
    logic       in_isr_q, in_isr_d;

    logic mem_wait;
    logic send_wait;
    logic full_stall;
    logic load_use;
    logic any_hazard;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
        .id_p0_addr  (id_p0_addr),
        .id_p1_addr  (id_p1_addr),
        .id_use_p0   (id_use_p0),
        .id_use_p1   (id_use_p1),
        .ex_dst_addr (ex_dst_addr),
        .ex_we       (ex_we),
        .ex_mem_re   (ex_mem_re),
        .load_use    (load_use)
    );

    always_comb begin
        mem_wait   = mem_access && !mem_rdy;
        send_wait  = ex_send && spart_full;
        full_stall = mem_wait || send_wait;
        any_hazard = full_stall || mispredict || load_use;
    end

    // Pipeline controls. While in STORE the vector redirect owns the front end;
    // only the whole-pipe waits can still hold it.
    always_comb begin
        pc_stall      = 1'b0;
        pc_sel        = PC_SEQ;
        if_id_stall   = 1'b0;
        if_id_nop     = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_stall  = 1'b0;
        store_current = 1'b0;

        if (state_q == ST_STORE) begin
            store_current = 1'b1;
            pc_sel        = PC_IRQ;
            if_id_nop     = 1'b1;
        end

        if (full_stall) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
        end else if (state_q != ST_STORE) begin
            if (mispredict) begin
                pc_sel      = PC_BR;
                if_id_nop   = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        irq_pend_d = irq_pend_q;
        in_isr_d   = in_isr_q;

        case (state_q)
            ST_RUN:   if (irq_pend_q && !any_hazard) state_d = ST_STORE;
            ST_STORE: if (!full_stall)               state_d = ST_ACK;
            ST_ACK:                                  state_d = ST_RUN;
            default:                                 state_d = ST_RUN;
        endcase

        if (state_q == ST_ACK) begin
            irq_pend_d = 1'b0;
        end else if (irq && !in_isr_q) begin
            irq_pend_d = 1'b1;
        end

        // Entering the ISR wins over an rti seen in the acknowledge cycle.
        if (state_q == ST_ACK) begin
            in_isr_d = 1'b1;
        end else if (rti) begin
            in_isr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            irq_pend_q <= 1'b0;
            in_isr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_pend_q <= irq_pend_d;
            in_isr_q   <= in_isr_d;
        end
    end

    assign irq_ack = (state_q == ST_ACK);
    assign in_isr  = in_isr_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the controller.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  id_p0_addr, id_p1_addr, ex_dst_addr;
    logic        id_use_p0, id_use_p1, ex_we, ex_mem_re;
    logic        mem_access, mem_rdy, ex_send, spart_full, mispredict, irq, rti;
    logic        pc_stall, if_id_stall, if_id_nop, id_ex_stall, id_ex_flush;
    logic        ex_mem_stall, store_current, irq_ack, in_isr;
    logic [1:0]  pc_sel;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.REG_AW(4), .CNT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_p0_addr    (id_p0_addr),
        .id_p1_addr    (id_p1_addr),
        .id_use_p0     (id_use_p0),
        .id_use_p1     (id_use_p1),
        .ex_dst_addr   (ex_dst_addr),
        .ex_we         (ex_we),
        .ex_mem_re     (ex_mem_re),
        .mem_access    (mem_access),
        .mem_rdy       (mem_rdy),
        .ex_send       (ex_send),
        .spart_full    (spart_full),
        .mispredict    (mispredict),
        .irq           (irq),
        .rti           (rti),
        .pc_stall      (pc_stall),
        .pc_sel        (pc_sel),
        .if_id_stall   (if_id_stall),
        .if_id_nop     (if_id_nop),
        .id_ex_stall   (id_ex_stall),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_stall  (ex_mem_stall),
        .store_current (store_current),
        .irq_ack       (irq_ack),
        .in_isr        (in_isr),
        .stall_cnt     (stall_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Model state: phase 0 = running, 1 = redirecting to vector, 2 = acknowledging.
    int          m_phase;
    bit          m_pend, m_isr;
    int unsigned m_cnt;
    int          stall_seen;
    int          store_at, ack_at, cyc;

    function automatic logic [10:0] pack_obs();
        return {pc_stall, pc_sel, if_id_stall, if_id_nop, id_ex_stall,
                id_ex_flush, ex_mem_stall, store_current, irq_ack, in_isr};
    endfunction

    function automatic bit whole_wait();
        return (mem_access && !mem_rdy) || (ex_send && spart_full);
    endfunction

    function automatic bit lu_hazard();
        bit hit;
        hit = (id_use_p0 && id_p0_addr == ex_dst_addr) || (id_use_p1 && id_p1_addr == ex_dst_addr);
        return ex_mem_re && ex_we && (ex_dst_addr != 4'd0) && hit;
    endfunction

    // Expected controls from the rule table: waits freeze every stage; during the
    // vector redirect the front end is squashed; otherwise first matching rule.
    function automatic logic [10:0] model_out();
        bit ps, ifs, nop, ies, flu, ems, sc;
        logic [1:0] sel;
        ps = 0; ifs = 0; nop = 0; ies = 0; flu = 0; ems = 0; sc = 0; sel = 2'b00;
        if (m_phase == 1) begin
            sc = 1; sel = 2'b10; nop = 1;
        end
        if (whole_wait()) begin
            ps = 1; ifs = 1; ies = 1; ems = 1;
        end else if (m_phase != 1 && mispredict) begin
            sel = 2'b01; nop = 1; flu = 1;
        end else if (m_phase != 1 && lu_hazard()) begin
            ps = 1; ifs = 1; flu = 1;
        end
        return {ps, sel, ifs, nop, ies, flu, ems, sc, (m_phase == 2), m_isr};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_pend = 0; m_isr = 0; m_cnt = 0;
    endtask

    task automatic inputs_idle();
        id_p0_addr = 0; id_p1_addr = 0; ex_dst_addr = 0;
        id_use_p0 = 0; id_use_p1 = 0; ex_we = 0; ex_mem_re = 0;
        mem_access = 0; mem_rdy = 0; ex_send = 0; spart_full = 0;
        mispredict = 0; irq = 0; rti = 0;
    endtask

    // Called at the falling edge after inputs are set; checks, then advances one cycle.
    task automatic step(input string tag);
        logic [10:0] exp;
        bit busy;
        int nphase;
        bit npend, nisr;
        #1;
        exp = model_out();
        check({tag, "_ctl"}, 32'(pack_obs()), 32'(exp));
        check({tag, "_cnt"}, 32'(stall_cnt), PERF ? m_cnt : 32'd0);
        if (pc_stall) stall_seen++;
        if (store_current && store_at < 0) store_at = cyc;
        if (irq_ack && ack_at < 0) ack_at = cyc;
        busy   = whole_wait() || mispredict || lu_hazard();
        nphase = m_phase;
        if (m_phase == 0 && m_pend && !busy) nphase = 1;
        else if (m_phase == 1 && !whole_wait()) nphase = 2;
        else if (m_phase == 2) nphase = 0;
        npend = (m_phase == 2) ? 1'b0 : (m_pend || (irq && !m_isr));
        nisr  = (m_phase == 2) ? 1'b1 : (rti ? 1'b0 : m_isr);
        if (exp[10] && m_cnt != 32'hffff) m_cnt++;
        @(posedge clk);
        m_phase = nphase; m_pend = npend; m_isr = nisr;
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        inputs_idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_ctl", 32'(pack_obs()), 32'd0);
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        cyc = 0;
        rst_n = 1'b1;
        inputs_idle();
        @(negedge clk);
        apply_reset();

        // Load-use on p1 = r3: exactly one bubble.
        ex_mem_re = 1; ex_we = 1; ex_dst_addr = 3; id_p1_addr = 3; id_use_p1 = 1;
        stall_seen = 0;
        step("lu_r3");
        check("lu_r3_ies", 32'(id_ex_stall), 32'd0);
        inputs_idle();
        step("lu_after");
        check("lu_bubbles", stall_seen, 1);
        // Destination r0 never stalls.
        ex_mem_re = 1; ex_we = 1; ex_dst_addr = 0; id_p1_addr = 0; id_use_p1 = 1;
        stall_seen = 0;
        step("lu_r0");
        check("lu_r0_stalls", stall_seen, 0);

        // Three-cycle data-memory wait.
        apply_reset();
        stall_seen = 0;
        mem_access = 1; mem_rdy = 0;
        for (int i = 0; i < 3; i++) step("memw");
        mem_rdy = 1;
        step("memw_done");
        check("memw_cycles", stall_seen, 3);
        check("memw_cnt", 32'(stall_cnt), PERF ? 32'd3 : 32'd0);

        // Mispredict wins over a coincident load-use.
        inputs_idle();
        mispredict = 1; ex_mem_re = 1; ex_we = 1; ex_dst_addr = 5; id_p0_addr = 5; id_use_p0 = 1;
        #1;
        check("mp_sel", 32'(pc_sel), 32'd1);
        check("mp_pcstall", 32'(pc_stall), 32'd0);
        step("mp_lu");

        // Interrupt raised during a 2-cycle mem wait.
        inputs_idle();
        store_at = -1; ack_at = -1;
        irq = 1; mem_access = 1; mem_rdy = 0;
        step("irq_mw0");
        irq = 0;
        step("irq_mw1");
        mem_access = 0;
        for (int i = 0; i < 10 && ack_at < 0; i++) step("irq_entry");
        check("irq_store_seen", 32'(store_at >= 0), 32'd1);
        check("irq_ack_lat", ack_at - store_at, 1);
        check("irq_in_isr", 32'(in_isr), 32'd1);
        // A second request is masked until rti.
        store_at = -1;
        irq = 1;
        for (int i = 0; i < 4; i++) step("irq_masked");
        check("irq_masked_store", 32'(store_at), 32'hffffffff);
        irq = 0; rti = 1;
        step("rti");
        rti = 0;
        for (int i = 0; i < 5; i++) step("post_rti");

        // SPART backpressure for four cycles.
        inputs_idle();
        stall_seen = 0;
        ex_send = 1; spart_full = 1;
        for (int i = 0; i < 4; i++) step("send_wait");
        spart_full = 0;
        step("send_go");
        check("send_cycles", stall_seen, 4);

        // Reset asserted while in STORE.
        inputs_idle();
        irq = 1;
        for (int i = 0; i < 6 && m_phase != 1; i++) step("to_store");
        check("reached_store", m_phase, 1);
        inputs_idle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_store_ctl", 32'(pack_obs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("after_rst");

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            id_p0_addr  = 4'($urandom_range(0, 3));
            id_p1_addr  = 4'($urandom_range(0, 3));
            ex_dst_addr = 4'($urandom_range(0, 3));
            id_use_p0   = 1'($urandom_range(0, 1));
            id_use_p1   = 1'($urandom_range(0, 1));
            ex_we       = 1'($urandom_range(0, 1));
            ex_mem_re   = 1'($urandom_range(0, 2) == 0);
            mem_access  = 1'($urandom_range(0, 4) == 0);
            mem_rdy     = 1'($urandom_range(0, 1));
            ex_send     = 1'($urandom_range(0, 5) == 0);
            spart_full  = 1'($urandom_range(0, 1));
            mispredict  = 1'($urandom_range(0, 7) == 0);
            irq         = 1'($urandom_range(0, 9) == 0);
            rti         = 1'($urandom_range(0, 19) == 0);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central hazard and sequencing controller for the five-stage processor pipeline. It generates every stall, flush and bubble control for the IF_ID, ID_EX and EX_MEM pipeline registers and the PC mux. It detects load-use hazards, data-memory wait states, SPART send backpressure and branch mispredicts. It also sequences interrupt entry through the ID_EX `store_current` path, which writes the return address to r15.

## Interface

Parameters:
- `REG_AW`, default 4: register address width.
- `CNT_W`, default 16: width of the performance stall counter.

Ports:
- `clk`, in, 1: system clock; all state updates on rising edge.
- `rst_n`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `id_p0_addr`, `id_p1_addr`, in, REG_AW: source registers of the instruction in ID.
- `id_use_p0`, `id_use_p1`, in, 1: ID instruction actually reads p0 / p1.
- `ex_dst_addr`, in, REG_AW: destination register of the instruction in EX.
- `ex_we`, `ex_mem_re`, in, 1: EX instruction writes a register / is a load.
- `mem_access`, in, 1: MEM stage has an active data read or write.
- `mem_rdy`, in, 1: data memory completes this cycle.
- `ex_send`, in, 1: EX instruction is a SPART send.
- `spart_full`, in, 1: SPART transmit buffer full.
- `mispredict`, in, 1: EX resolved a branch against its prediction.
- `irq`, in, 1: level interrupt request.
- `rti`, in, 1: return-from-interrupt retired in EX.
- `pc_stall`, out, 1: hold PC.
- `pc_sel`, out, 2: 00 sequential/predicted, 01 EX branch target, 10 IRQ vector.
- `if_id_stall`, out, 1: hold IF_ID.
- `if_id_nop`, out, 1: force NOP into the IF_ID `instr_in`.
- `id_ex_stall`, `id_ex_flush`, out, 1: ID_EX controls. Flush has priority inside ID_EX.
- `ex_mem_stall`, out, 1: hold EX_MEM.
- `store_current`, out, 1: ID_EX captures the return address into r15.
- `irq_ack`, out, 1: one-cycle acknowledge.
- `in_isr`, out, 1: interrupts masked.
- `stall_cnt`, out, CNT_W: stall-cycle counter (see Configuration).

## Operation

Per-cycle conditions are combinational and evaluated in priority order. The first true condition wins.
1. **mem_wait** (`mem_access & !mem_rdy`): assert `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall`.
2. **send_wait** (`ex_send & spart_full`): assert the same four stalls as mem_wait.
3. **mispredict**: `pc_sel`=01, `if_id_nop`=1, `id_ex_flush`=1, no stalls.
4. **load_use**: true when all of the following hold:
   - `ex_mem_re & ex_we` and `ex_dst_addr`≠0;
   - ex_dst matches `id_p0_addr` with `id_use_p0`, or matches `id_p1_addr` with `id_use_p1`.
   
   Response: `pc_stall`, `if_id_stall`, `id_ex_flush` (one bubble). Do not assert `id_ex_stall`.
5. Otherwise all controls are 0 and `pc_sel`=00.

Interrupt FSM, states RUN, STORE, ACK:
- `irq_pend` sets on `irq & !in_isr` and clears in ACK.
- RUN→STORE when `irq_pend` is set and conditions 1–4 are all false this cycle. Otherwise remain in RUN, so the interrupt is deferred, never dropped.
- STORE, one cycle:
  - `store_current`=1, `pc_sel`=10, `if_id_nop`=1.
  - Then go to ACK.
  - If mem_wait or send_wait arises during STORE, the stalls take effect and the FSM holds in STORE. `store_current` stays asserted, which is harmless because ID_EX gives stall priority.
- ACK, one cycle: `irq_ack`=1, set `in_isr`, clear `irq_pend`, then go to RUN.
- `rti` clears `in_isr`. If `rti` and `irq` arrive in the same cycle, `in_isr` clears and `irq_pend` sets the following cycle.

Reset values: state RUN, `irq_pend`=0, `in_isr`=0, `stall_cnt`=0. All outputs are 0, with `pc_sel`=00.

## Timing

- Controls are combinational from inputs and state, with zero-cycle latency into the pipeline registers' next edge.
- Load-use costs exactly 1 bubble. Mispredict costs 2 squashed slots (IF_ID and ID_EX).
- Interrupt entry latency is at least 2 cycles from `irq` (pend, STORE) plus any hazard deferral. `irq_ack` arrives 1 cycle after `store_current`.
- Reset asserted mid-STORE/ACK returns to RUN asynchronously. The pending interrupt is lost.

## Configuration

- `PIPE_CTRL_PERF_EN` defined: `stall_cnt` increments on every cycle with `pc_stall` set, saturating at all-ones. It clears only on reset.
- Undefined: no counter register is built and `stall_cnt` is tied to 0.

## Structure

- Package `pipe_ctrl_pkg` holds:
  - the FSM state enum;
  - the `pc_sel` codes PC_SEQ/PC_BR/PC_IRQ;
  - the NOP instruction encoding;
  - the return-address register index (4'hf).
- Sub-module `hazard_detect` is the combinational load-use comparator: ID sources vs EX destination, with the r0 exclusion.

## Test plan

- Load writes r3 in EX while ID reads p1=r3 → exactly one cycle of `pc_stall`/`if_id_stall`/`id_ex_flush`. Same case with dst=r0 → no stall.
- `mem_access`=1, `mem_rdy`=0 for 3 cycles → all four stalls high for exactly 3 cycles; `stall_cnt`=3 with PERF_EN, 0 without.
- `mispredict` coincident with load_use → only mispredict actions (`pc_sel`=01, `id_ex_flush`, `if_id_nop`), no `pc_stall`.
- `irq` raised during a 2-cycle mem_wait → `store_current` on the first free cycle, `irq_ack` on the next, `in_isr`=1. A second `irq` is ignored until `rti`.
- `ex_send` with `spart_full` held 4 cycles, then released → 4 stall cycles, then normal advance.
- `rst_n` low while in STORE → all outputs 0 immediately; RUN after release.
